// File: rtl/mux_n_pipe_if.sv
// Bus bundle for mux_n_pipe: packed inputs and select, flush, the output beat
// handshake and the illegal-select counter.
interface mux_n_pipe_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             err_count;

  // Upstream/downstream environment side
  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_err, out_valid, err_count
  );

  // Selector block side
  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_err, out_valid, err_count
  );
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way operand/forwarding selector with a registered,
// valid/ready output stage and flush. Out-of-range select yields zero data
// tagged with out_err, and a saturating count of such beats is kept.
// Optional feature macro: MUX_SKID_EN adds a skid register so in_ready is
// driven only from flops and flush.
module mux_n_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4
) (
  input  logic         clk,
  input  logic         rst,
  mux_n_pipe_if.slave  bus
);
  localparam int unsigned SEL_W   = $clog2(NUM_IN);
  localparam logic [15:0] ERR_MAX = 16'hFFFF;

  logic [WIDTH-1:0] sel_data_c;
  logic             sel_err_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             out_free_c;

  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             out_err_q,   out_err_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      err_count_q, err_count_d;

  // Select the addressed input; out-of-range select gives zero plus error tag
  always_comb begin
    sel_data_c = '0;
    sel_err_c  = (32'(bus.sel) >= NUM_IN);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k)) sel_data_c = bus.in_data[k*WIDTH +: WIDTH];
    end
    if (sel_err_c) sel_data_c = '0;
  end

  // Output register is free when empty or being consumed this cycle
  assign out_free_c = !out_valid_q || bus.out_ready;
  assign accept_c   = bus.in_valid && in_ready_c;

`ifdef MUX_SKID_EN
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;
  logic             skid_valid_q, skid_valid_d;

  // Registered ready: only an occupied skid register or flush stalls upstream
  assign in_ready_c = !skid_valid_q && !bus.flush;

  // Next-state for the output/skid pair and the error counter
  always_comb begin
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;
    skid_valid_d = skid_valid_q;
    err_count_d  = err_count_q;

    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free_c) begin
      if (skid_valid_q) begin
        // Skid holds the oldest beat; no accept is possible while it is full
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        out_data_d  = sel_data_c;
        out_err_d   = sel_err_c;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_data_d  = sel_data_c;
      skid_err_d   = sel_err_c;
      skid_valid_d = 1'b1;
    end

    if (accept_c && sel_err_c && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // Skid register state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
      skid_valid_q <= skid_valid_d;
    end
  end
`else
  // Single register: accept whenever the output frees this cycle
  assign in_ready_c = out_free_c && !bus.flush;

  // Next-state for the output register and the error counter
  always_comb begin
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    err_count_d = err_count_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept_c) begin
      out_data_d  = sel_data_c;
      out_err_d   = sel_err_c;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept_c && sel_err_c && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end
`endif

  // Output register and error counter state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err_count = err_count_q;
endmodule

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-way operand/forwarding selector with a registered, flow-controlled output stage. It is the next generation of the pipeline's 3:1 forwarding muxes. Input count and data width are configurable. An out-of-range select produces a deterministic zero plus an error tag instead of X. A valid/ready handshake with flush lets it sit directly on a pipeline-stage boundary, for example ID/EX operand capture.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of selectable inputs (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, asynchronous, active-high
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  input  SEL_W  binary select, sampled with in_data
- in_valid  input  1  upstream beat present
- in_ready  output  1  block can accept a beat this cycle
- flush  input  1  synchronous pipeline flush
- out_data  output  WIDTH  registered selected data
- out_err  output  1  tag on the output beat: sel was >= NUM_IN
- out_valid  output  1  output beat present
- out_ready  input  1  downstream accepts
- err_count  output  16  saturating count of accepted illegal-select beats

## Operation
- Accept condition: in_valid && in_ready. The selected value and err tag are captured together.
- Selection:
  - sel < NUM_IN: data = input[sel], err = 0.
  - sel >= NUM_IN: data = 0, err = 1.
- Output handshake: a beat is consumed when out_valid && out_ready. out_data and out_err stay stable while out_valid && !out_ready.
- err_count increments by 1 on each accepted beat with err = 1. It saturates at 16'hFFFF and is cleared only by rst; flush does not clear it.
- flush:
  - Forces in_ready = 0 in that cycle, so no accept and no err_count increment.
  - Invalidates all held beats (out_valid = 0 and skid empty) on the next edge. out_data keeps its last value.
- Reset (asynchronous): out_valid = 0, out_data = 0, out_err = 0, err_count = 0, skid empty. in_ready = 1 once rst is low and flush is low.
- No beat is ever duplicated or reordered; beats leave in acceptance order.

## Timing
- Latency: a beat accepted at edge n appears on out_valid/out_data after edge n (1 cycle).
- Throughput: 1 beat/cycle while out_ready = 1.
- in_ready:
  - With the skid buffer: driven only by flops and flush (no combinational path from out_ready).
  - Without it: in_ready = (!out_valid || out_ready) && !flush.
- Simultaneous accept and consume: the new beat replaces the output register in the same edge, with no bubble.
- Simultaneous flush and out_ready: the current output beat is counted as consumed by downstream, then cleared.
- rst asserted mid-transfer: all beats are dropped immediately and no partial state is retained.

## Configuration
- MUX_SKID_EN defined: a 2-entry stage is compiled in (output register plus one skid register).
  - in_ready = !skid_valid && !flush, with skid_valid a flop.
  - A beat accepted while the output is stalled goes to the skid register and moves to the output when it frees.
  - Full throughput is sustained with a registered in_ready.
- MUX_SKID_EN undefined: a single output register only.
  - in_ready is combinational from out_ready as given in Timing.
  - Same data, err and counter behaviour; no skid register is generated.

## Test plan
- Basic select, NUM_IN=4, WIDTH=32, inputs 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, out_ready=1 -> out_data=0x33333333, out_err=0, out_valid one cycle after accept.
- Illegal select, NUM_IN=3, sel=3 -> out_data=0, out_err=1, err_count 0->1. Repeating 70000 accepts -> err_count holds at 0xFFFF.
- Backpressure, out_ready=0 for 5 cycles with in_valid=1 streaming 0xA,0xB,0xC:
  - MUX_SKID_EN: 2 beats held, in_ready=0 from the cycle after the second accept.
  - Otherwise: 1 beat held.
  - Release -> 0xA,0xB,0xC in order, no loss or duplicate.
- Flush with held beats (skid full), flush=1 one cycle with in_valid=1 -> no accept that cycle, out_valid=0 next cycle, err_count unchanged.
- Async reset asserted between clock edges with out_valid=1 -> out_valid, out_data, out_err, err_count go to 0 immediately without a clock. After release, in_ready=1.
- Back-to-back streaming of 100 random sel/data beats with random out_ready -> output sequence matches the scoreboard model exactly, and err_count equals the number of illegal sels accepted.
